// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_multi.sv
// Multi-channel programmable clock divider.
// Each channel emits a flop-driven 50%-duty clock of period 2*(DIV+1), a
// one-cycle TICK on every rising edge of that clock, and a BUSY flag.
// Start and stop never shorten a phase. A new ratio is picked up only at a
// low-phase entry, which is IDLE->LO or HI->LO.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_multi #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RN,
    input  logic [CHANNELS-1:0]           EN,
    input  logic [CHANNELS*DIV_WIDTH-1:0] DIV,
    output logic [CHANNELS-1:0]           Z,
    output logic [CHANNELS-1:0]           TICK,
    output logic [CHANNELS-1:0]           BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t                 r_state;
        logic [DIV_WIDTH-1:0]   r_cnt;
        logic [DIV_WIDTH-1:0]   r_div_act;
        logic                   r_z;
        logic                   r_tick;
        logic                   r_busy;
        logic [DIV_WIDTH-1:0]   w_div;
        logic                   w_done;

        assign w_div  = DIV[g*DIV_WIDTH +: DIV_WIDTH];
        assign w_done = (r_cnt == r_div_act);

        // Per-channel phase sequencer: IDLE -> LO -> HI -> LO ... -> IDLE
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_div_act <= '0;
                r_z       <= 1'b0;
                r_tick    <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_z <= 1'b0;
                        if (EN[g]) begin
                            r_div_act <= w_div;
                            r_cnt     <= '0;
                            r_state   <= ST_LO;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_LO: begin
                        if (!w_done) begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end else if (EN[g]) begin
                            r_z     <= 1'b1;
                            r_tick  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_HI;
                        end else begin
                            // low phase finished with no run request: stop without a rising edge
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_HI: begin
                        if (!w_done) begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end else begin
                            r_z       <= 1'b0;
                            r_cnt     <= '0;
                            r_div_act <= w_div;
                            if (EN[g]) begin
                                r_state <= ST_LO;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_z     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign Z[g]    = r_z;
        assign TICK[g] = r_tick;
        assign BUSY[g] = r_busy;
    end

endmodule
